// File: rtl/shift_reg_frame.sv
// Framed universal shift register: serial-in/parallel-out and parallel-load/serial-out.
// Optional macro SHIFT_REG_FRAME_PARITY_EN adds po_parity, exp_parity and parity_err.

module shift_reg_frame #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [WIDTH-1:0]           pi,
    input  logic                       shift,
    input  logic                       si,
    output logic                       so,
    output logic [WIDTH-1:0]           sr,
    output logic [WIDTH-1:0]           po,
    output logic                       word_done,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt
`ifdef SHIFT_REG_FRAME_PARITY_EN
    ,
    input  logic                       exp_parity,
    output logic                       po_parity,
    output logic                       parity_err
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    // si only reaches state through shifted, which is used only while shift is high
    always_comb begin
        shifted = sr_q;
        so      = 1'b0;
        if (MSB_FIRST) begin
            shifted = {sr_q[WIDTH-2:0], si};
            so      = sr_q[WIDTH-1];
        end else begin
            shifted = {si, sr_q[WIDTH-1:1]};
            so      = sr_q[0];
        end
    end

    always_comb begin
        sr_d     = sr_q;
        po_d     = po_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        complete = 1'b0;
        if (load) begin
            sr_d  = pi;
            cnt_d = '0;
        end else if (shift) begin
            sr_d = shifted;
            if (cnt_q == LAST) begin
                cnt_d    = '0;
                po_d     = shifted;
                done_d   = 1'b1;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            po_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            po_q   <= po_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign sr        = sr_q;
    assign po        = po_q;
    assign bit_cnt   = cnt_q;
    assign word_done = done_q;

`ifdef SHIFT_REG_FRAME_PARITY_EN
    logic par_q, par_d;
    logic err_q, err_d;

    always_comb begin
        par_d = par_q;
        err_d = 1'b0;
        if (complete) begin
            par_d = ^shifted;
            err_d = (^shifted) != exp_parity;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            par_q <= par_d;
            err_q <= err_d;
        end
    end

    assign po_parity  = par_q;
    assign parity_err = err_q;
`else
    logic unused_complete;
    assign unused_complete = complete;
`endif

endmodule

// File: tb/tb_shift_reg_frame.sv
// Directed bench for shift_reg_frame: MSB-first instance plus an LSB-first instance,
// expected words queued as stimulus is driven and popped on word_done.

module tb_shift_reg_frame;

    logic       clk = 1'b0;
    logic       rst, load, shift, si;
    logic [7:0] pi;
    logic       so, word_done;
    logic [7:0] sr, po;
    logic [2:0] bit_cnt;

    logic       l_load, l_shift, l_si;
    logic [7:0] l_pi;
    logic       l_so, l_word_done;
    logic [7:0] l_sr, l_po;
    logic [2:0] l_bit_cnt;

`ifdef SHIFT_REG_FRAME_PARITY_EN
    logic exp_parity, po_parity, parity_err;
    logic l_po_parity, l_parity_err;
`endif

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_q[$];

    always #10 clk = ~clk;

    shift_reg_frame #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .pi        (pi),
        .shift     (shift),
        .si        (si),
        .so        (so),
        .sr        (sr),
        .po        (po),
        .word_done (word_done),
        .bit_cnt   (bit_cnt)
`ifdef SHIFT_REG_FRAME_PARITY_EN
        ,
        .exp_parity(exp_parity),
        .po_parity (po_parity),
        .parity_err(parity_err)
`endif
    );

    shift_reg_frame #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .load      (l_load),
        .pi        (l_pi),
        .shift     (l_shift),
        .si        (l_si),
        .so        (l_so),
        .sr        (l_sr),
        .po        (l_po),
        .word_done (l_word_done),
        .bit_cnt   (l_bit_cnt)
`ifdef SHIFT_REG_FRAME_PARITY_EN
        ,
        .exp_parity(exp_parity),
        .po_parity (l_po_parity),
        .parity_err(l_parity_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_shift(input logic b, input logic exp_done, input string tag);
        shift = 1'b1;
        si    = b;
        step();
        check({tag, "_done"}, word_done, exp_done);
        if (word_done && exp_q.size() > 0) check({tag, "_po"}, po, exp_q.pop_front());
    endtask

    task automatic shift_word(input logic [7:0] w, input string tag);
        exp_q.push_back(w);
        for (int i = 7; i >= 0; i--) do_shift(w[i], i == 0, tag);
    endtask

    initial begin
        logic [7:0] a;
        rst = 1'b1; load = 1'b1; shift = 1'b1; si = 1'b1; pi = 8'hFF;
        l_load = 1'b0; l_shift = 1'b0; l_si = 1'b0; l_pi = 8'h00;
`ifdef SHIFT_REG_FRAME_PARITY_EN
        exp_parity = 1'b0;
`endif
        step();
        step();
        check("rst_sr", sr, 8'h00);
        check("rst_po", po, 8'h00);
        check("rst_cnt", bit_cnt, 3'd0);
        check("rst_done", word_done, 1'b0);
        check("rst_so", so, 1'b0);
        rst = 1'b0; shift = 1'b0; load = 1'b0; si = 1'b0;

        // parallel load then serial out
        a = 8'hA5;
        load = 1'b1; pi = a;
        step();
        load = 1'b0;
        check("load_sr", sr, 8'hA5);
        check("load_cnt", bit_cnt, 3'd0);
        exp_q.push_back(8'h00);
        for (int i = 7; i >= 0; i--) begin
            check("so_bit", so, a[i]);
            do_shift(1'b0, i == 0, "unload");
        end
        check("unload_sr", sr, 8'h00);
        shift = 1'b0;

        // serial in 0xB3, hold through idle
        shift_word(8'hB3, "b3");
        shift = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_done", word_done, 1'b0);
            check("idle_po", po, 8'hB3);
        end

        // back-to-back words
        shift_word(8'hAA, "aa1");
        shift_word(8'hAA, "aa2");
        shift = 1'b0;
        check("aa_pending", exp_q.size(), 0);

        // reset mid-word discards the partial word
        for (int i = 0; i < 4; i++) do_shift(1'b1, 1'b0, "part");
        check("part_cnt", bit_cnt, 3'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_cnt", bit_cnt, 3'd0);
        check("mid_rst_po", po, 8'h00);
        check("mid_rst_done", word_done, 1'b0);
        shift_word(8'hFF, "ff");
        shift = 1'b0;
        step();
        check("ff_po_hold", po, 8'hFF);

        // LSB-first instance
        a = 8'h01;
        exp_q.push_back(8'h01);
        for (int i = 0; i < 8; i++) begin
            l_shift = 1'b1;
            l_si    = (i == 0);
            step();
            check("lsb_done", l_word_done, i == 7);
            if (l_word_done && exp_q.size() > 0) check("lsb_po", l_po, exp_q.pop_front());
        end
        l_shift = 1'b0; l_si = 1'b0;
        check("lsb_sr", l_sr, a);

`ifdef SHIFT_REG_FRAME_PARITY_EN
        exp_parity = 1'b0;
        shift_word(8'h07, "p07");
        shift = 1'b0;
        check("p07_err", parity_err, 1'b1);
        check("p07_par", po_parity, 1'b1);
        step();
        check("p07_err_clr", parity_err, 1'b0);
        shift_word(8'h03, "p03");
        shift = 1'b0;
        check("p03_err", parity_err, 1'b0);
        check("p03_par", po_parity, 1'b0);
`endif

        check("all_words_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
